// File: rtl/deserializer16_pkg.sv
// Shared constants and FSM state encoding for the 16-bit serial-to-parallel deserializer.
package deserializer16_pkg;

    localparam int FRAME_BITS = 16;
    localparam int IDX_W      = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

endpackage

// File: rtl/deserializer16_bit_counter.sv
// Bit-index counter for the frame being assembled; load1 restarts at bit 1, inc wraps 15 -> 0.
module frame_bit_counter
    import deserializer16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load1,
    input  logic             inc,
    output logic [IDX_W-1:0] count
);

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load1) begin
            count <= IDX_W'(1);
        end else if (inc) begin
            count <= count + IDX_W'(1);
        end
    end

endmodule

// File: rtl/deserializer16.sv
// Deserializer: assembles LSB-first serial frames into 16-bit words behind a one-word
// valid/ready output buffer, with sticky overrun and frame-error flags.
module deserializer16
#(
    parameter int FRAME_BITS = 16
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sin_valid,
    input  logic                  sin_start,
    input  logic                  sin_data,
    input  logic                  err_clr,
    input  logic                  pout_ready,
    output logic [FRAME_BITS-1:0] pout_data,
    output logic                  pout_valid,
    output logic [3:0]            bit_count,
    output logic                  overrun,
    output logic                  frame_err
);

    import deserializer16_pkg::*;

    state_t                state;
    logic [FRAME_BITS-1:0] asm_q;
    logic                  start_bit;
    logic                  data_bit;
    logic                  last_bit;
    logic                  buf_free;
    logic [FRAME_BITS-1:0] word_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        start_bit = 1'b0;
        data_bit  = 1'b0;
        last_bit  = 1'b0;
        if (sin_valid) begin
            start_bit = sin_start;
            data_bit  = !sin_start && (state == ST_RECV);
            last_bit  = data_bit && (bit_count == IDX_W'(FRAME_BITS - 1));
        end
    end

    assign buf_free  = !pout_valid || pout_ready;
    assign word_next = {sin_data, asm_q[FRAME_BITS-2:0]};

    frame_bit_counter u_counter (
        .clk   (clk),
        .rst   (rst),
        .load1 (start_bit),
        .inc   (data_bit),
        .count (bit_count)
    );

    // NOTE: the assembly register is reset too, so a reset mid-frame leaves no stale bits behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            asm_q <= '0;
        end else begin
            if (start_bit) begin
                state <= ST_RECV;
                asm_q <= FRAME_BITS'(sin_data);
            end else if (data_bit) begin
                asm_q[bit_count] <= sin_data;
                if (last_bit) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    // A word completing while the buffer is held is dropped; the buffered word stays put.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pout_data  <= '0;
            pout_valid <= 1'b0;
        end else if (last_bit && buf_free) begin
            pout_data  <= word_next;
            pout_valid <= 1'b1;
        end else if (pout_valid && pout_ready) begin
            pout_valid <= 1'b0;
        end
    end

    // Set has priority over err_clr when both happen on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (last_bit && !buf_free) || (overrun && !err_clr);
            frame_err <= (start_bit && state == ST_RECV) || (frame_err && !err_clr);
        end
    end

endmodule
